carga_tempo: RTL and testbench

- Keypad time-entry and load controller for the timer's MM:SS countdown chain.
- Accepts BCD digit strobes and shifts them into a 4-digit entry register, newest digit at seconds-ones.
- On start, validates the entry and drives the parallel data buses plus an active-low load pulse into the down-counters (mod-10 ones, mod-6 tens).
- Sits between the keypad decoder and the counter chain, on the write side of the counters' data/loadn interface.

---
 rtl/carga_tempo_pkg.sv | 22 ++
 rtl/carga_tempo_registrador_digitos.sv | 39 +++
 rtl/carga_tempo.sv | 128 ++++++++++++
 tb/tb_carga_tempo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/carga_tempo_pkg.sv
// Shared timer definitions for the time-entry and load path.
// Holds the controller state encoding, BCD digit width/limits and the
// default highest legal seconds-tens digit.
package carga_tempo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         BCD_W            = 4;
  localparam int         SEC_TENS_MAX_DEF = 5;
  localparam logic [3:0] BCD_MAX          = 4'd9;

  // Keypad codes 10..15 are not digits.
  function automatic logic is_bcd(input logic [BCD_W-1:0] code);
    return code <= BCD_MAX;
  endfunction

endpackage

// File: rtl/carga_tempo_registrador_digitos.sv
// Four-digit BCD entry register. A shift pushes a new digit in at
// seconds-ones and moves every other digit one place up; the oldest
// (minutes-tens) digit falls off the end.
// Ports:
//   clk      system clock, rising edge
//   clearn   synchronous active-low reset
//   shift    shift digit in this cycle
//   clear    synchronous clear of all digits
//   digit    incoming BCD digit
//   sec_ones, sec_tens, min_ones, min_tens  registered digit outputs
module registrador_digitos
  import carga_tempo_pkg::*;
(
  input  logic             clk,
  input  logic             clearn,
  input  logic             shift,
  input  logic             clear,
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens
);

  always_ff @(posedge clk) begin
    if (!clearn || clear) begin
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
    end else if (shift) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= digit;
    end
  end

endmodule

// File: rtl/carga_tempo.sv
// Keypad time-entry and load controller for the MM:SS countdown chain.
// Collects BCD key strobes into a 4-digit entry, validates it on start and
// pulses the active-low load strobe into the down-counters.
//
// state | meaning
// IDLE  | no digits entered
// ENTRY | 1..4 digits entered
// LOAD  | loadn held low for LOAD_CYCLES cycles
// DONE  | load_done high for one cycle, entry cleared on exit
//
// Ports:
//   clk          system clock, rising edge
//   clearn       synchronous active-low reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     BCD digit, codes 10..15 ignored
//   start        load the entered time into the counters
//   clear_entry  discard entered digits
//   busy         countdown running; blocks entry and load
//   sec_ones, sec_tens, min_ones, min_tens  counter data buses
//   loadn        active-low load strobe to all counters
//   entry_count  digits entered, saturating at 4
//   load_done    one-cycle pulse at end of load
//   err          one-cycle pulse when start is rejected
module carga_tempo
  import carga_tempo_pkg::*;
#(
  parameter int LOAD_CYCLES  = 1,
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_code,
  input  logic             start,
  input  logic             clear_entry,
  input  logic             busy,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             loadn,
  output logic [2:0]       entry_count,
  output logic             load_done,
  output logic             err
);

  localparam logic [1:0] LOAD_LAST = 2'(LOAD_CYCLES - 1);

  state_t     state;
  logic [1:0] load_cnt;

  logic entry_phase;
  logic start_act;
  logic start_ok;
  logic key_ok;
  logic digits_clear;

  assign entry_phase = (state == IDLE) || (state == ENTRY);

  // A start only acts (and so wins over a same-cycle key) when there is
  // an entry to load; a start in IDLE leaves the key path untouched.
  assign start_act    = (state == ENTRY) && !clear_entry && !busy && start;
  assign start_ok     = start_act && (sec_tens <= 4'(SEC_TENS_MAX));
  assign key_ok       = entry_phase && !clear_entry && !busy && !start_act &&
                        key_valid && is_bcd(key_code);
  // Leaving DONE wipes the entry; the counters captured it during LOAD.
  assign digits_clear = (entry_phase && clear_entry) || (state == DONE);

  registrador_digitos u_digitos (
    .clk      (clk),
    .clearn   (clearn),
    .shift    (key_ok),
    .clear    (digits_clear),
    .digit    (key_code),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens)
  );

  always_ff @(posedge clk) begin
    if (!clearn) begin
      state       <= IDLE;
      load_cnt    <= '0;
      entry_count <= '0;
      loadn       <= 1'b1;
      load_done   <= 1'b0;
      err         <= 1'b0;
    end else begin
      load_done <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (clear_entry) begin
            state       <= IDLE;
            entry_count <= '0;
          end else if (start_act) begin
            if (start_ok) begin
              state    <= LOAD;
              loadn    <= 1'b0;
              load_cnt <= LOAD_LAST;
            end else begin
              err <= 1'b1;
            end
          end else if (key_ok) begin
            state <= ENTRY;
            if (entry_count != 3'd4) entry_count <= entry_count + 3'd1;
          end
        end
        LOAD: begin
          if (load_cnt == 2'd0) begin
            state     <= DONE;
            loadn     <= 1'b1;
            load_done <= 1'b1;
          end else begin
            load_cnt <= load_cnt - 2'd1;
          end
        end
        DONE: begin
          state       <= IDLE;
          entry_count <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carga_tempo.sv
module tb_carga_tempo;

  logic       clk;
  logic       clearn, key_valid, start, clear_entry, busy;
  logic [3:0] key_code;

  logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
  logic [2:0] a_ec, b_ec;
  logic       a_ln, a_ld, a_er, b_ln, b_ld, b_er;

  carga_tempo #(.LOAD_CYCLES(1)) dut_a (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .clear_entry(clear_entry), .busy(busy),
    .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
    .loadn(a_ln), .entry_count(a_ec), .load_done(a_ld), .err(a_er));

  carga_tempo #(.LOAD_CYCLES(3)) dut_b (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .clear_entry(clear_entry), .busy(busy),
    .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
    .loadn(b_ln), .entry_count(b_ec), .load_done(b_ld), .err(b_er));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: digits as a plain array (0=sec_ones .. 3=min_tens),
  // a digit count, and "load cycles remaining" / "done pending" flags.
  int md[2][4];
  int mcnt[2];
  int mleft[2];
  bit mdone[2];
  bit mloadn[2], mld[2], merr[2];
  int lc[2] = '{1, 3};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!clearn) begin
        for (int j = 0; j < 4; j++) md[i][j] = 0;
        mcnt[i] = 0; mleft[i] = 0; mdone[i] = 0;
        mloadn[i] = 1; mld[i] = 0; merr[i] = 0;
      end else begin
        merr[i] = 0;
        mld[i]  = 0;
        if (mleft[i] > 0) begin
          mleft[i]--;
          if (mleft[i] == 0) begin
            mloadn[i] = 1; mld[i] = 1; mdone[i] = 1;
          end
        end else if (mdone[i]) begin
          mdone[i] = 0;
          for (int j = 0; j < 4; j++) md[i][j] = 0;
          mcnt[i] = 0;
        end else if (clear_entry) begin
          for (int j = 0; j < 4; j++) md[i][j] = 0;
          mcnt[i] = 0;
        end else if (!busy && start && mcnt[i] > 0) begin
          if (md[i][1] <= 5) begin
            mleft[i] = lc[i]; mloadn[i] = 0;
          end else begin
            merr[i] = 1;
          end
        end else if (!busy && key_valid && key_code <= 9) begin
          for (int j = 3; j > 0; j--) md[i][j] = md[i][j-1];
          md[i][0] = int'(key_code);
          mcnt[i] = (mcnt[i] >= 4) ? 4 : mcnt[i] + 1;
        end
      end
    end
  endtask

  task automatic check_model();
    check("a_sec_ones", 8'(a_so), 8'(md[0][0]));
    check("a_sec_tens", 8'(a_st), 8'(md[0][1]));
    check("a_min_ones", 8'(a_mo), 8'(md[0][2]));
    check("a_min_tens", 8'(a_mt), 8'(md[0][3]));
    check("a_entry_count", 8'(a_ec), 8'(mcnt[0]));
    check("a_loadn", 8'(a_ln), 8'(mloadn[0]));
    check("a_load_done", 8'(a_ld), 8'(mld[0]));
    check("a_err", 8'(a_er), 8'(merr[0]));
    check("b_sec_ones", 8'(b_so), 8'(md[1][0]));
    check("b_sec_tens", 8'(b_st), 8'(md[1][1]));
    check("b_min_ones", 8'(b_mo), 8'(md[1][2]));
    check("b_min_tens", 8'(b_mt), 8'(md[1][3]));
    check("b_entry_count", 8'(b_ec), 8'(mcnt[1]));
    check("b_loadn", 8'(b_ln), 8'(mloadn[1]));
    check("b_load_done", 8'(b_ld), 8'(mld[1]));
    check("b_err", 8'(b_er), 8'(merr[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic quiet();
    clearn = 1; key_valid = 0; key_code = 0; start = 0; clear_entry = 0; busy = 0;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1; key_code = k;
    cycle();
    key_valid = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int lowcnt;

  initial begin
    quiet();
    clearn = 0;
    cycle();
    clearn = 1;
    check("rst_loadn", 8'(a_ln), 8'd1);
    check("rst_entry_count", 8'(a_ec), 8'd0);

    // keys 1,2,3,0 then start
    key(1); key(2); key(3); key(0);
    check("k1230_min_tens", 8'(a_mt), 8'd1);
    check("k1230_min_ones", 8'(a_mo), 8'd2);
    check("k1230_sec_tens", 8'(a_st), 8'd3);
    check("k1230_sec_ones", 8'(a_so), 8'd0);
    start = 1; cycle(); start = 0;
    check("k1230_loadn_low", 8'(a_ln), 8'd0);
    lowcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (!b_ln) lowcnt++;
      if (i == 0) begin
        check("k1230_load_done", 8'(a_ld), 8'd0);
      end
      cycle();
      if (i == 0) begin
        check("k1230_load_done_pulse", 8'(a_ld), 8'd1);
        check("k1230_loadn_back", 8'(a_ln), 8'd1);
      end
      if (i == 1) begin
        check("k1230_cleared_count", 8'(a_ec), 8'd0);
        check("k1230_cleared_min_tens", 8'(a_mt), 8'd0);
      end
    end
    check("lc3_loadn_low_cycles", 8'(lowcnt), 8'd3);

    // keys 9,9 then start: rejected
    key(9); key(9);
    start = 1; cycle(); start = 0;
    check("k99_err", 8'(a_er), 8'd1);
    check("k99_loadn", 8'(a_ln), 8'd1);
    check("k99_sec_tens", 8'(a_st), 8'd9);
    cycle();
    check("k99_err_once", 8'(a_er), 8'd0);
    clear_entry = 1; cycle(); clear_entry = 0;

    // keys 1..5, then invalid 12
    key(1); key(2); key(3); key(4); key(5);
    check("k12345_count", 8'(a_ec), 8'd4);
    check("k12345_min_tens", 8'(a_mt), 8'd2);
    key(12);
    check("k12_sec_ones", 8'(a_so), 8'd5);
    check("k12_err", 8'(a_er), 8'd0);
    clear_entry = 1; cycle(); clear_entry = 0;

    // start together with key 7
    key(4); key(5);
    start = 1; key_valid = 1; key_code = 7; cycle();
    start = 0; key_valid = 0;
    check("startkey_sec_ones", 8'(a_so), 8'd5);
    check("startkey_loadn", 8'(a_ln), 8'd0);
    idle_cycles(6);

    // busy blocks keys and start; clear_entry still honoured
    key(3);
    busy = 1;
    key(3); key(3);
    start = 1; cycle(); start = 0;
    check("busy_count", 8'(a_ec), 8'd1);
    check("busy_loadn", 8'(a_ln), 8'd1);
    clear_entry = 1; cycle(); clear_entry = 0;
    check("busy_clear_count", 8'(a_ec), 8'd0);
    busy = 0;
    cycle();

    // reset during the second LOAD cycle of the 3-cycle instance
    key(5); key(0);
    start = 1; cycle(); start = 0;
    check("lc3_loadn_low", 8'(b_ln), 8'd0);
    cycle();
    clearn = 0; cycle(); clearn = 1;
    check("lc3_rst_loadn", 8'(b_ln), 8'd1);
    check("lc3_rst_load_done", 8'(b_ld), 8'd0);
    check("lc3_rst_sec_tens", 8'(b_st), 8'd0);
    cycle();
    check("lc3_no_done_after", 8'(b_ld), 8'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      clearn      = ($urandom_range(0, 99) != 0);
      key_valid   = ($urandom_range(0, 1) == 1);
      key_code    = 4'($urandom_range(0, 15));
      start       = ($urandom_range(0, 9) == 0);
      clear_entry = ($urandom_range(0, 29) == 0);
      busy        = (mleft[0] == 0 && mleft[1] == 0) ? ($urandom_range(0, 6) == 0) : 1'b0;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
